// File: rtl/quant_zigzag.sv
// Quantizes one registered 8x8 DCT coefficient block with per-entry reciprocals
// and streams the results in JPEG zigzag order over a valid/ready handshake.
module quant_zigzag #(
  parameter int BLOCK_SIZE = 8,
  parameter int COEF_W     = 32,
  parameter int OUT_W      = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][COEF_W-1:0]    dct_block,
  input  logic [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0][15:0]          q_recip,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [OUT_W-1:0]                                     out_coef,
  output logic [5:0]                                           out_index,
  output logic                                                 out_last
);

  localparam int PW = COEF_W + 17;

  typedef enum logic {IDLE, SCAN} state_t;

  // Natural (8*row+col) position of each zigzag index.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t              state;
  logic [COEF_W-1:0]   coef_mem  [64];
  logic [15:0]         recip_mem [64];
  logic                accept;
  logic [5:0]          next_index;
  logic [5:0]          nat_index;
  logic [PW-1:0]       coef_ext;
  logic [PW-1:0]       recip_ext;
  logic signed [PW-1:0] product;
  logic                negative;
  logic [PW-1:0]       magnitude;
  logic [PW-1:0]       rounded;
  logic [OUT_W-1:0]    quant;

  localparam logic [PW-1:0] HALF    = PW'(1) << 23;
  localparam logic [PW-1:0] NEG_LIM = PW'(1) << (OUT_W - 1);

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < BLOCK_SIZE; r++) begin
        for (int c = 0; c < BLOCK_SIZE; c++) begin
          coef_mem[6'(BLOCK_SIZE*r + c)]  <= dct_block[r][c];
          recip_mem[6'(BLOCK_SIZE*r + c)] <= q_recip[r][c];
        end
      end
    end
  end

  // One shared multiplier works on whichever entry will be presented next.
  always_comb begin
    next_index = out_valid ? out_index + 6'd1 : 6'd0;
    nat_index  = ZIGZAG[next_index];
    coef_ext   = {{17{coef_mem[nat_index][COEF_W-1]}}, coef_mem[nat_index]};
    recip_ext  = {{(PW-16){1'b0}}, recip_mem[nat_index]};
    product    = $signed(coef_ext) * $signed(recip_ext);
    negative   = product[PW-1];
    magnitude  = negative ? PW'(-product) : PW'(product);
    rounded    = (magnitude + HALF) >> 24;
    quant      = '0;
    if (negative) begin
      if (rounded >= NEG_LIM)
        quant = {1'b1, {(OUT_W-1){1'b0}}};
      else
        quant = OUT_W'(0) - rounded[OUT_W-1:0];
    end else begin
      if (rounded > NEG_LIM - PW'(1))
        quant = {1'b0, {(OUT_W-1){1'b1}}};
      else
        quant = rounded[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= SCAN;
        end
        SCAN: begin
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_coef  <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_coef  <= quant;
              out_index <= next_index;
              out_last  <= (next_index == 6'd63);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quant_zigzag.sv
// Scoreboard bench for quant_zigzag: expected coefficients are queued at
// block accept and compared in order as handshakes occur.
module tb_quant_zigzag;

  typedef struct {
    logic [15:0] coef;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [7:0][7:0][31:0]       dct_block = '0;
  logic [7:0][7:0][15:0]       q_recip = '0;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [15:0]                 out_coef;
  logic [5:0]                  out_index;
  logic                        out_last;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] tb_coef  [64];
  logic [15:0] tb_recip [64];
  int   zz_row [64];
  int   zz_col [64];

  quant_zigzag dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dct_block(dct_block), .q_recip(q_recip), .out_valid(out_valid),
    .out_ready(out_ready), .out_coef(out_coef), .out_index(out_index),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard: each handshake consumes the oldest expected entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_output idx=%0d coef=%0d required none", out_index, $signed(out_coef));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_coef !== e.coef || out_index !== e.idx || out_last !== e.last)
        begin
          errors++;
          $display("[TB] FAIL scoreboard got idx=%0d coef=%0d last=%b required idx=%0d coef=%0d last=%b",
                   out_index, $signed(out_coef), out_last, e.idx, $signed(e.coef), e.last);
        end
      end
    end
  end

  function automatic logic [15:0] quant_model(logic [31:0] c, logic [15:0] q);
    longint p, m, r;
    p = longint'($signed(c)) * longint'(q);
    m = (p < 0) ? -p : p;
    r = (m + 64'sd8388608) >>> 24;
    if (p < 0) r = -r;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic void build_zigzag();
    int r, c;
    r = 0;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      zz_row[i] = r;
      zz_col[i] = c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endfunction

  task automatic push_expected();
    exp_t e;
    int n;
    for (int i = 0; i < 64; i++) begin
      n      = 8*zz_row[i] + zz_col[i];
      e.coef = quant_model(tb_coef[n], tb_recip[n]);
      e.idx  = 6'(i);
      e.last = (i == 63);
      exp_q.push_back(e);
    end
  endtask

  task automatic load_inputs();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        dct_block[r][c] = tb_coef[8*r + c];
        q_recip[r][c]   = tb_recip[8*r + c];
      end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after accept.
  task automatic send_block();
    load_inputs();
    push_expected();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid && in_ready && exp_q.size() == 0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic fill_random();
    for (int n = 0; n < 64; n++) begin
      tb_coef[n]  = 32'($signed($urandom_range(0, 2000000)) - 1000000);
      tb_recip[n] = 16'($urandom);
    end
  endtask

  task automatic applyStimulus_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (out_coef !== 16'd0) begin errors++; $display("[TB] FAIL reset_out_coef got %0d required 0", out_coef); end
    checks++; if (out_index !== 6'd0) begin errors++; $display("[TB] FAIL reset_out_index got %0d required 0", out_index); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %b required 0", out_last); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus_idle();
  endtask

  task automatic test_rounding();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 64; n++) begin
        tb_coef[n]  = (pass == 0) ? 32'd256 : 32'hFFFF_FF00;
        tb_recip[n] = 16'h8000;
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rounding_ready got %b required 1", in_ready); end
      send_block();
      wait_drain(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rounding_drain got timeout required drained"); end
    end
  endtask

  task automatic test_zigzag();
    bit ok;
    int run;
    for (int n = 0; n < 64; n++) begin
      tb_coef[n]  = 32'(n) << 8;
      tb_recip[n] = 16'hFFFF;
    end
    out_ready = 1'b1;
    send_block();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zigzag_latency_early got %b required 0", out_valid); end
    run = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1 && in_ready === 1'b0) run++;
    end
    checks++; if (run != 64) begin errors++; $display("[TB] FAIL zigzag_consecutive got %0d required 64", run); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL zigzag_return_idle got valid=%b ready=%b required 0/1", out_valid, in_ready); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zigzag_drain got timeout required drained"); end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int n = 0; n < 64; n++) begin
      case (n % 4)
        0: begin tb_coef[n] = 32'h7FFF_FFFF; tb_recip[n] = 16'hFFFF; end
        1: begin tb_coef[n] = 32'h8000_0000; tb_recip[n] = 16'hFFFF; end
        2: begin tb_coef[n] = $urandom; tb_recip[n] = 16'h0000; end
        default: begin tb_coef[n] = $urandom; tb_recip[n] = 16'($urandom); end
      endcase
    end
    send_block();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL saturation_drain got timeout required drained"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit prev_stall;
    logic [15:0] prev_coef;
    logic [5:0]  prev_idx;
    logic        prev_last;
    fill_random();
    send_block();
    prev_stall = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_coef !== prev_coef || out_index !== prev_idx || out_last !== prev_last) begin
          errors++;
          $display("[TB] FAIL stall_stable got v=%b idx=%0d coef=%0d required v=1 idx=%0d coef=%0d",
                   out_valid, out_index, $signed(out_coef), prev_idx, $signed(prev_coef));
        end
      end
      if (out_valid) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL scan_in_ready got %b required 0", in_ready); end
      end
      if (!out_valid && in_ready && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      out_ready  = 1'($urandom_range(0, 1));
      prev_stall = out_valid && !out_ready;
      prev_coef  = out_coef;
      prev_idx   = out_index;
      prev_last  = out_last;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL backpressure_drain got timeout required drained"); end
  endtask

  task automatic test_isolation();
    bit ok;
    fill_random();
    out_ready = 1'b1;
    send_block();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i >= 5 && i < 30) begin
        in_valid  = 1'($urandom_range(0, 1));
        dct_block = {64{32'($urandom)}};
        q_recip   = {64{16'($urandom)}};
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL isolation_in_ready got %b required 0", in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL isolation_drain got timeout required drained"); end
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL isolation_second_block got valid=%b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_block();
    bit ok;
    bit found;
    fill_random();
    out_ready = 1'b1;
    send_block();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_index == 6'd20) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL midreset_reach20 got timeout required index 20"); end
    rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || out_coef !== 16'd0 || out_index !== 6'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got v=%b coef=%0d idx=%0d last=%b rdy=%b required 0/0/0/0/1",
               out_valid, out_coef, out_index, out_last, in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale got valid=%b required 0", out_valid); end
    fill_random();
    send_block();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midreset_next_drain got timeout required drained"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int gap;
    fill_random();
    out_ready = 1'b1;
    send_block();
    fill_random();
    load_inputs();
    in_valid = 1'b1;
    gap = 0;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (in_ready) begin
        gap = k;
        break;
      end
    end
    push_expected();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (gap != 65) begin errors++; $display("[TB] FAIL b2b_spacing got %0d required 65", gap); end
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_drain got timeout required drained"); end
  endtask

  task automatic checkOutput();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    build_zigzag();
    test_reset();
    test_rounding();
    test_zigzag();
    test_saturation();
    test_backpressure();
    test_isolation();
    test_reset_mid_block();
    test_back_to_back();
    checkOutput();
    $finish;
  end

endmodule

// File: doc/quant_zigzag.md
QUANT_ZIGZAG -- requirements
Module: quant_zigzag

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 8, meaning block edge length; only 8 is supported.
REQ-002 SHALL have parameter COEF_W, default 32, meaning input coefficient width, signed fixed point with 8 fractional bits.
REQ-003 SHALL have parameter OUT_W, default 16, meaning quantized output width, signed integer.
REQ-004 SHALL use a single clock: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL use reset: rst  input  1  asynchronous, active-low (0 = reset).
REQ-006 SHALL have in_valid  input  1  dct_block and q_recip are valid.
REQ-007 SHALL have in_ready  output  1  block accepted when in_valid and in_ready are both high.
REQ-008 SHALL have dct_block  input  COEF_W x [8][8]  DCT coefficients indexed [row][col].
REQ-009 SHALL have q_recip  input  16 x [8][8]  unsigned Q0.16 reciprocal of the quantizer step, indexed [row][col].
REQ-010 SHALL have out_valid  input/output direction output  1  out_coef, out_index and out_last are valid.
REQ-011 SHALL have out_ready  input  1  downstream accepts the output on this cycle.
REQ-012 SHALL have out_coef  output  OUT_W  quantized coefficient.
REQ-013 SHALL have out_index  output  6  zigzag position 0..63 of out_coef.
REQ-014 SHALL have out_last  output  1  high with out_index == 63.

Function
REQ-015 SHALL implement the states IDLE and SCAN; in_ready = 1 only in IDLE.
REQ-016 SHALL register all 64 dct_block and q_recip entries on the accept edge and move IDLE->SCAN; later input changes SHALL have no effect on the current block.
REQ-017 SHALL emit coefficients in standard JPEG zigzag order (row,col): 0:(0,0), 1:(0,1), 2:(1,0), 3:(2,0), 4:(1,1), 5:(0,2), ... 63:(7,7).
REQ-018 SHALL compute the signed product coef x recip exactly, at least COEF_W+17 bits wide.
REQ-019 SHALL shift the product right by 24, rounding half away from zero: add 2^23 to the magnitude, truncate, then restore the sign.
REQ-020 SHALL saturate the rounded result to the range [-32768, 32767].
REQ-021 SHALL yield out_coef = 0 when recip = 0.
REQ-022 SHALL assert out_valid with index 0 on the first edge after the accept edge, giving a latency of 1 cycle.
REQ-023 SHALL advance to the next index on each edge where out_valid && out_ready, for a throughput of 1 coefficient per cycle with no gaps.
REQ-024 SHALL hold out_coef, out_index and out_last stable while out_valid && !out_ready; out_valid SHALL NOT drop without a handshake.
REQ-025 SHALL move SCAN->IDLE on the handshake with out_last; out_valid = 0 and in_ready = 1 from the next cycle.
REQ-026 SHALL NOT accept a new block in the same cycle as the last handshake, so the minimum spacing between accepts is 66 cycles.
REQ-027 SHALL ignore in_valid during SCAN.

Reset
REQ-028 SHALL, while rst = 0, force state IDLE, in_ready = 1, out_valid = 0, out_coef = 0, out_index = 0 and out_last = 0, asynchronously.
REQ-029 SHALL, when rst is asserted mid-SCAN, abort the block immediately; after release, no stale output SHALL appear and the next accepted block SHALL start at index 0.

Verification
REQ-030 SHALL be checked for rounding: all coef = 256 (1.0), recip = 0x8000 -> 64 outputs of +1; all coef = -256 -> 64 outputs of -1.
REQ-031 SHALL be checked for zigzag order: coef[r][c] = (8r+c)<<8, recip = 0xFFFF, out_ready = 1 -> out_coef sequence 0, 1, 8, 16, 9, 2, ... 63, matching out_index 0..63; out_last only at 63; out_valid first high 1 cycle after accept; 64 consecutive valid cycles.
REQ-032 SHALL be checked for saturation and zero: coef = 0x7FFFFFFF, recip = 0xFFFF -> 32767; coef = 0x80000000 -> -32768; recip = 0 -> 0.
REQ-033 SHALL be checked for backpressure: random out_ready at 50% -> no lost or duplicated index, outputs stable while stalled, in_ready = 0 throughout SCAN.
REQ-034 SHALL be checked for input isolation: change dct_block and pulse in_valid during SCAN -> current block outputs unchanged and no second block accepted until IDLE.
REQ-035 SHALL be checked for reset mid-block: assert rst at index 20 -> all outputs 0 and in_ready = 1 immediately; after release, the next block starts at index 0.
